// File: rtl/fetch_instruction.sv
// fetch_instruction: program counter and instruction register for the fetch stage
module fetch_instruction #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] curr_instr
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_addr <= ADDR_W'(RESET_PC);
            curr_instr <= '0;
        end else begin
            instr_addr <= instr_addr + 1'b1;
            curr_instr <= instr;
        end
    end
endmodule

// File: tb/tb_fetch_instruction.sv
// tb_fetch_instruction: vector table, corner sequences and random fetch checks
module tb_fetch_instruction;
    logic        clk = 0;
    logic        rst = 0;
    logic [7:0]  instr_addr;
    logic [15:0] instr;
    logic [15:0] curr_instr;
    logic [15:0] drv = '0;
    logic        use_mem = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int          edges;
        logic [7:0]  exp_addr;
        logic [15:0] exp_ir;
    } vec_t;

    vec_t vecs[5];

    fetch_instruction dut (
        .clk(clk),
        .rst(rst),
        .instr_addr(instr_addr),
        .instr(instr),
        .curr_instr(curr_instr)
    );

    // combinational memory returns {addr, ~addr} or a directly driven word
    assign instr = use_mem ? {instr_addr, ~instr_addr} : drv;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [15:0] word, prev;
        vecs[0] = '{1,   8'h01, 16'h00FF};
        vecs[1] = '{2,   8'h02, 16'h01FE};
        vecs[2] = '{3,   8'h03, 16'h02FD};
        vecs[3] = '{256, 8'h00, 16'hFF00};
        vecs[4] = '{257, 8'h01, 16'h00FF};

        // reset hold with toggling instr
        for (int i = 0; i < 4; i++) begin
            drv = 16'($urandom);
            tick();
            chk("hold_addr", 32'(instr_addr), 32'h00);
            chk("hold_ir", 32'(curr_instr), 32'h0000);
        end

        // sequential fetch and wrap-around from the vector table
        use_mem = 1;
        rst = 1;
        n = 0;
        for (int v = 0; v < 5; v++) begin
            while (n < vecs[v].edges) begin
                tick();
                n++;
            end
            chk($sformatf("seq_addr[%0d]", v), 32'(instr_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("seq_ir[%0d]", v), 32'(curr_instr), 32'(vecs[v].exp_ir));
        end

        // async reset mid-run at PC=5
        rst = 0;
        #1;
        rst = 1;
        repeat (5) tick();
        chk("pre_async_addr", 32'(instr_addr), 32'h05);
        #2;
        rst = 0;
        #1;
        chk("async_addr", 32'(instr_addr), 32'h00);
        chk("async_ir", 32'(curr_instr), 32'h0000);
        #1;
        rst = 1;
        tick();
        chk("post_async_addr", 32'(instr_addr), 32'h01);
        chk("post_async_ir", 32'(curr_instr), 32'h00FF);

        // output isolation: instr changes mid-cycle
        use_mem = 0;
        drv = 16'h1234;
        tick();
        prev = curr_instr;
        chk("iso_first", 32'(prev), 32'h1234);
        #3;
        drv = 16'hABCD;
        #2;
        chk("iso_hold", 32'(curr_instr), 32'h1234);
        tick();
        chk("iso_capture", 32'(curr_instr), 32'hABCD);

        // release coincident with a rising edge
        use_mem = 1;
        rst = 0;
        #1;
        @(posedge clk);
        rst <= 1;
        #1;
        chk("edge_rel_addr", 32'(instr_addr), 32'h00);
        chk("edge_rel_ir", 32'(curr_instr), 32'h0000);
        tick();
        chk("edge_next_addr", 32'(instr_addr), 32'h01);
        chk("edge_next_ir", 32'(curr_instr), 32'h00FF);

        // random words against an edge-count model, with occasional async resets
        use_mem = 0;
        rst = 0;
        #1;
        rst = 1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            word = 16'($urandom);
            drv = word;
            tick();
            n++;
            chk("rnd_addr", 32'(instr_addr), 32'(n % 256));
            chk("rnd_ir", 32'(curr_instr), 32'(word));
            if ($urandom_range(0, 31) == 0) begin
                #1;
                rst = 0;
                #1;
                chk("rnd_rst_addr", 32'(instr_addr), 32'h00);
                chk("rnd_rst_ir", 32'(curr_instr), 32'h0000);
                rst = 1;
                n = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_instruction.md
Name: fetch_instruction

Overview:
- Instruction-fetch stage of the 3-stage pipeline processor.
- Holds the program counter (PC) and drives it to instruction memory as the fetch address.
- Captures the returned 16-bit instruction word into the instruction register (IR), which feeds the decode stage.
- Fetches one instruction per clock; the PC advances sequentially.

Parameters:
- ADDR_W, 8, width of the PC / instruction address.
- DATA_W, 16, width of the instruction word and IR.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_addr  output  ADDR_W  current PC, driven to instruction memory.
- instr  input  DATA_W  instruction word returned by memory for instr_addr (combinational memory, same cycle).
- curr_instr  output  DATA_W  IR contents; the instruction handed to decode.
- Port order: clk, rst, instr_addr, instr, curr_instr.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst).
- State consists of two registers:
  - PC (ADDR_W bits), driven directly on instr_addr.
  - IR (DATA_W bits), driven directly on curr_instr.
- Both outputs come straight from registers; there is no combinational path from instr to any output.
- Reset:
  - While rst=0, PC=RESET_PC (instr_addr=0x00) and IR=0 (curr_instr=0x0000).
  - Takes effect immediately on the falling edge of rst, without waiting for clk.
  - Holds for as long as rst stays low; clock edges are ignored.
- Normal operation (rst=1), on each rising clk edge:
  - IR <= instr, i.e. the word memory returns for the current PC.
  - PC <= PC + 1, modulo 2^ADDR_W.
- Latency:
  - instr_addr changes only just after a rising edge.
  - memory must present instr before the next rising edge.
  - curr_instr shows the word fetched from address A during the cycle in which instr_addr = A+1.
- First cycle after reset release:
  - The first rising edge with rst=1 captures the word at RESET_PC and moves the PC to RESET_PC+1.
  - No bubble is inserted.
- Wrap-around: PC 0xFF increments to 0x00 with no flag and no stall.
- Reset mid-operation: the asynchronous assert overrides any in-flight update. After release, fetch restarts from RESET_PC.
- Reset release coincident with a rising edge: that edge is treated as still in reset, and the first fetch capture occurs on the following edge.
- instr X/Z: captured into IR as-is, with no masking. The PC still increments.
- No stall, branch or redirect inputs in this revision. The PC is strictly sequential.

Test Plan:
- Reset hold: rst=0, run several clocks with instr toggling -> instr_addr=0x00 and curr_instr=0x0000 throughout.
- Sequential fetch: memory model instr = {instr_addr, ~instr_addr}; release rst.
  - 1st edge -> curr_instr=0x00FF, instr_addr=0x01.
  - 2nd edge -> curr_instr=0x01FE, instr_addr=0x02.
  - 3rd edge -> curr_instr=0x02FD, instr_addr=0x03.
- Wrap-around: run 256 edges after reset.
  - Edge with PC=0xFF -> curr_instr=0xFF00, instr_addr=0x00.
  - Next edge -> curr_instr=0x00FF, instr_addr=0x01.
- Async reset mid-run: at PC=0x05, drive rst=0 between clock edges -> instr_addr=0x00 and curr_instr=0x0000 within the same timestep, no clk edge required. Release -> the next edge gives curr_instr=0x00FF.
- Output isolation: change instr mid-cycle (e.g. 0x1234 -> 0xABCD before the edge) -> curr_instr does not change until the edge, then equals 0xABCD.
- Release on edge: deassert rst exactly at a rising edge -> PC stays 0x00 through that edge and advances on the next one.
